// File: rtl/prince_sr_rc_stage.sv
// rtl/prince_sr_rc_stage.sv - PRINCE SR/RC/k1 round stage with internal round tracking and skid buffer
// Forward rounds 1-5 apply SR then RC^k1; inverse rounds 6-10 apply RC^k1 then SR^-1.
module prince_sr_rc_stage #(
  parameter int USE_SKID = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  input  logic [63:0] k1,
  input  logic        in_first,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] y,
  output logic [3:0]  out_round,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        round_err
);
  localparam logic [3:0] RCNT_IDLE = 4'd0;
  // Nibble i of each table names the source nibble for output nibble i.
  localparam logic [63:0] SR_FWD = 64'h05af49e38d27c16b;
  localparam logic [63:0] SR_INV = 64'h0da741eb852fc963;

  function automatic logic [63:0] shift_rows(input logic [63:0] s, input logic inv);
    logic [63:0] r;
    logic [3:0]  src;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      src = inv ? SR_INV[63 - 4*i -: 4] : SR_FWD[63 - 4*i -: 4];
      r[63 - 4*i -: 4] = s[63 - 4*int'(src) -: 4];
    end
    return r;
  endfunction

  function automatic logic [63:0] round_const(input logic [3:0] r);
    case (r)
      4'd1:    round_const = 64'h13198a2e03707344;
      4'd2:    round_const = 64'ha4093822299f31d0;
      4'd3:    round_const = 64'h082efa98ec4e6c89;
      4'd4:    round_const = 64'h452821e638d01377;
      4'd5:    round_const = 64'hbe5466cf34e90c6c;
      4'd6:    round_const = 64'h7ef84f78fd955cb1;
      4'd7:    round_const = 64'h85840851f1ac43aa;
      4'd8:    round_const = 64'hc882d32f25323c54;
      4'd9:    round_const = 64'h64a51195e0e3610d;
      4'd10:   round_const = 64'hd3b5a399ca0c2399;
      default: round_const = 64'h0;
    endcase
  endfunction

  logic        out_valid_q, out_valid_d;
  logic [63:0] out_y_q, out_y_d;
  logic [3:0]  out_round_q, out_round_d;
  logic        skid_valid_q, skid_valid_d;
  logic [63:0] skid_y_q, skid_y_d;
  logic [3:0]  skid_round_q, skid_round_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic        err_q, err_d;

  logic        accept;
  logic        drain;
  logic [3:0]  beat_round;
  logic [3:0]  beat_rcnt_next;
  logic        beat_err;
  logic [63:0] rc_k;
  logic [63:0] beat_y;

  assign in_ready  = (USE_SKID != 0) ? !skid_valid_q : (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid_q && out_ready;
  assign y         = out_y_q;
  assign out_round = out_round_q;
  assign out_last  = (out_round_q == 4'd10);
  assign out_valid = out_valid_q;
  assign round_err = err_q;

  // A stray in_first or a missing in_first both resynchronise to round 1.
  always_comb begin
    beat_round     = rcnt_q;
    beat_rcnt_next = rcnt_q;
    beat_err       = 1'b0;
    if (in_first || rcnt_q == RCNT_IDLE) begin
      beat_round     = 4'd1;
      beat_rcnt_next = 4'd2;
      beat_err       = (in_first && rcnt_q != RCNT_IDLE) || (!in_first && rcnt_q == RCNT_IDLE);
    end else begin
      beat_rcnt_next = (rcnt_q == 4'd10) ? RCNT_IDLE : rcnt_q + 4'd1;
    end
  end

  always_comb begin
    rc_k   = round_const(beat_round) ^ k1;
    beat_y = (beat_round <= 4'd5) ? (shift_rows(a, 1'b0) ^ rc_k)
                                  : shift_rows(a ^ rc_k, 1'b1);
  end

  always_comb begin
    rcnt_d       = rcnt_q;
    err_d        = err_q;
    out_valid_d  = out_valid_q;
    out_y_d      = out_y_q;
    out_round_d  = out_round_q;
    skid_valid_d = skid_valid_q;
    skid_y_d     = skid_y_q;
    skid_round_d = skid_round_q;
    if (accept) begin
      rcnt_d = beat_rcnt_next;
      err_d  = err_q || beat_err;
    end
    // The skid entry is always older than the incoming beat, so it drains first.
    if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_y_d      = skid_y_q;
        out_round_d  = skid_round_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_y_d     = beat_y;
          skid_round_d = beat_round;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_y_d     = beat_y;
          out_round_d = beat_round;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_y_d     = beat_y;
      skid_round_d = beat_round;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_y_q      <= '0;
      out_round_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_y_q     <= '0;
      skid_round_q <= '0;
      rcnt_q       <= RCNT_IDLE;
      err_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_y_q      <= out_y_d;
      out_round_q  <= out_round_d;
      skid_valid_q <= skid_valid_d;
      skid_y_q     <= skid_y_d;
      skid_round_q <= skid_round_d;
      rcnt_q       <= rcnt_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_prince_sr_rc_stage.sv
// tb/tb_prince_sr_rc_stage.sv - self-checking bench for prince_sr_rc_stage
// Reference model: nibble permutation tables, RC array and a queue scoreboard.
module tb_prince_sr_rc_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] a = '0;
  logic [63:0] k1 = '0;
  logic        in_first = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] y;
  logic [3:0]  out_round;
  logic        out_last;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        round_err;

  always #5 clk = ~clk;

  prince_sr_rc_stage #(.USE_SKID(1)) dut (
    .clk(clk), .rst(rst), .a(a), .k1(k1), .in_first(in_first), .in_valid(in_valid),
    .in_ready(in_ready), .y(y), .out_round(out_round), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .round_err(round_err)
  );

  typedef struct {
    logic [63:0] y;
    logic [3:0]  rnd;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t act_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int m_rcnt = 0;
  bit m_err = 0;

  int p_fwd[16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
  int p_inv[16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};
  logic [63:0] rc_tab[11] = '{64'h0,
    64'h13198a2e03707344, 64'ha4093822299f31d0, 64'h082efa98ec4e6c89,
    64'h452821e638d01377, 64'hbe5466cf34e90c6c, 64'h7ef84f78fd955cb1,
    64'h85840851f1ac43aa, 64'hc882d32f25323c54, 64'h64a51195e0e3610d,
    64'hd3b5a399ca0c2399};

  function automatic logic [63:0] perm(input logic [63:0] s, input bit inv);
    logic [63:0] o = '0;
    logic [63:0] nib;
    int src;
    for (int i = 0; i < 16; i++) begin
      src = inv ? p_inv[i] : p_fwd[i];
      nib = (s >> (60 - 4*src)) & 64'hf;
      o = o | (nib << (60 - 4*i));
    end
    return o;
  endfunction

  function automatic logic [63:0] model_y(input logic [63:0] av, input logic [63:0] kv, input int r);
    if (r <= 5) return perm(av, 1'b0) ^ rc_tab[r] ^ kv;
    return perm(av ^ kv ^ rc_tab[r], 1'b1);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_accept(input bit first, output int r);
    if (first) begin
      if (m_rcnt != 0) m_err = 1;
      r = 1;
      m_rcnt = 2;
    end else if (m_rcnt == 0) begin
      m_err = 1;
      r = 1;
      m_rcnt = 2;
    end else begin
      r = m_rcnt;
      m_rcnt = (r == 10) ? 0 : r + 1;
    end
  endtask

  // One clock: drive, record handshakes on both sides, advance to posedge+1.
  task automatic tick(input bit v, input bit first, input logic [63:0] av,
                      input logic [63:0] kv, input bit ordy);
    beat_t b;
    int r;
    bit acc, drn;
    in_valid = v; in_first = first; a = av; k1 = kv; out_ready = ordy;
    #2;
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) begin
      b.y = y; b.rnd = out_round; b.last = out_last; b.cyc = cyc;
      act_q.push_back(b);
    end
    if (acc) begin
      model_accept(first, r);
      b.y = model_y(av, kv, r); b.rnd = r[3:0]; b.last = (r == 10); b.cyc = cyc + 1;
      exp_q.push_back(b);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete(); act_q.delete();
    m_rcnt = 0; m_err = 0; acc_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (y !== 64'h0) begin bad++; $display("FAIL reset_y: got %h want 0", y); end
    total++; if (out_round !== 4'd0 || out_last !== 1'b0) begin bad++; $display("FAIL reset_round: got %0d/%b want 0/0", out_round, out_last); end
    total++; if (round_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", round_err); end
    do_reset();
  endtask

  task automatic test_fwd_sr();
    do_reset();
    tick(1, 1, 64'h0123456789abcdef, 64'h0, 0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fwd_valid: got %b want 1", out_valid); end
    total++; if (y !== 64'h16b6c3cd8e57b22f) begin bad++; $display("FAIL fwd_y: got %h want 16b6c3cd8e57b22f", y); end
    total++; if (out_round !== 4'd1 || out_last !== 1'b0) begin bad++; $display("FAIL fwd_round: got %0d/%b want 1/0", out_round, out_last); end
  endtask

  task automatic test_inv_sr();
    logic [63:0] kr;
    do_reset();
    for (int i = 0; i < 10; i++) tick(1, i == 0, 64'h0123456789abcdef, 64'h0, 1);
    tick(0, 0, 0, 0, 1); tick(0, 0, 0, 0, 1);
    total++; if (act_q.size() != 10) begin bad++; $display("FAIL inv_count: got %0d want 10", act_q.size()); end
    if (act_q.size() >= 6) begin
      total++;
      if (act_q[5].y !== perm(64'h0123456789abcdef ^ rc_tab[6], 1'b1) || act_q[5].rnd !== 4'd6) begin
        bad++; $display("FAIL inv_beat6: got %h r%0d want %h r6", act_q[5].y, act_q[5].rnd,
                        perm(64'h0123456789abcdef ^ rc_tab[6], 1'b1));
      end
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (act_q[i].y !== exp_q[i].y) begin bad++; $display("FAIL inv_beat%0d: got %h want %h", i + 1, act_q[i].y, exp_q[i].y); end
    end
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      kr = (pass == 0) ? 64'h0 : rnd64();
      for (int i = 0; i < 5; i++) tick(1, i == 0, rnd64(), rnd64(), 1);
      tick(1, 0, rc_tab[6] ^ kr, kr, 1);
      tick(0, 0, 0, 0, 1); tick(0, 0, 0, 0, 1);
      total++;
      if (act_q.size() != 6 || act_q[5].y !== 64'h0 || act_q[5].rnd !== 4'd6) begin
        bad++; $display("FAIL inv_zero%0d: got n=%0d y=%h want n=6 y=0", pass, act_q.size(), act_q[act_q.size() - 1].y);
      end
    end
  endtask

  task automatic test_full_block();
    do_reset();
    for (int i = 0; i < 10; i++) tick(1, i == 0, rnd64(), rnd64(), 1);
    tick(0, 0, 0, 0, 1); tick(0, 0, 0, 0, 1);
    total++; if (act_q.size() != 10) begin bad++; $display("FAIL blk_count: got %0d want 10", act_q.size()); end
    total++; if (acc_cnt != 10) begin bad++; $display("FAIL blk_accepts: got %0d want 10", acc_cnt); end
    if (act_q.size() == 10 && exp_q.size() == 10) begin
      total++; if (act_q[0].cyc != exp_q[0].cyc) begin bad++; $display("FAIL blk_latency: got cyc %0d want %0d", act_q[0].cyc, exp_q[0].cyc); end
      for (int i = 0; i < 10; i++) begin
        total++;
        if (act_q[i].rnd !== 4'(i + 1) || act_q[i].last !== (i == 9) || act_q[i].y !== exp_q[i].y ||
            act_q[i].cyc != act_q[0].cyc + i) begin
          bad++; $display("FAIL blk_beat%0d: got r%0d l%b %h c%0d want r%0d l%b %h c%0d", i, act_q[i].rnd,
                          act_q[i].last, act_q[i].y, act_q[i].cyc, i + 1, i == 9, exp_q[i].y, act_q[0].cyc + i);
        end
      end
    end
    tick(1, 1, rnd64(), rnd64(), 1);
    total++; if (round_err !== 1'b0 || out_round !== 4'd1) begin bad++; $display("FAIL blk_idle: got err=%b r%0d want err=0 r1", round_err, out_round); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, i == 0, rnd64(), rnd64(), 0);
    total++; if (acc_cnt != 2) begin bad++; $display("FAIL bp_accepts: got %0d want 2", acc_cnt); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b1 || y !== exp_q[0].y) begin bad++; $display("FAIL bp_hold: got v=%b %h want v=1 %h", out_valid, y, exp_q[0].y); end
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1);
    total++; if (act_q.size() != 2) begin bad++; $display("FAIL bp_drained: got %0d want 2", act_q.size()); end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (act_q[i].y !== exp_q[i].y || act_q[i].rnd !== exp_q[i].rnd) begin
        bad++; $display("FAIL bp_order%0d: got %h r%0d want %h r%0d", i, act_q[i].y, act_q[i].rnd, exp_q[i].y, exp_q[i].rnd);
      end
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_protocol();
    do_reset();
    tick(1, 1, rnd64(), rnd64(), 1);
    tick(1, 0, rnd64(), rnd64(), 1);
    tick(1, 0, rnd64(), rnd64(), 1);
    total++; if (round_err !== 1'b0 || out_round !== 4'd3) begin bad++; $display("FAIL proto_pre: got err=%b r%0d want err=0 r3", round_err, out_round); end
    tick(1, 1, rnd64(), rnd64(), 1);
    total++; if (round_err !== 1'b1 || out_round !== 4'd1) begin bad++; $display("FAIL proto_restart: got err=%b r%0d want err=1 r1", round_err, out_round); end
    total++; if (y !== exp_q[3].y) begin bad++; $display("FAIL proto_restart_y: got %h want %h", y, exp_q[3].y); end
    do_reset();
    tick(1, 0, rnd64(), rnd64(), 1);
    total++; if (round_err !== 1'b1 || out_round !== 4'd1 || y !== exp_q[0].y) begin
      bad++; $display("FAIL proto_idle: got err=%b r%0d %h want err=1 r1 %h", round_err, out_round, y, exp_q[0].y);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    tick(1, 0, rnd64(), rnd64(), 0);
    tick(1, 0, rnd64(), rnd64(), 0);
    total++; if (in_ready !== 1'b0 || round_err !== 1'b1) begin bad++; $display("FAIL mrst_pre: got rdy=%b err=%b want 0/1", in_ready, round_err); end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || round_err !== 1'b0) begin
      bad++; $display("FAIL mrst_flush: got v=%b rdy=%b err=%b want 0/1/0", out_valid, in_ready, round_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete(); act_q.delete(); m_rcnt = 0; m_err = 0; acc_cnt = 0;
    tick(1, 1, rnd64(), rnd64(), 1);
    total++; if (out_valid !== 1'b1 || out_round !== 4'd1 || round_err !== 1'b0 || y !== exp_q[0].y) begin
      bad++; $display("FAIL mrst_next: got v=%b r%0d err=%b %h want 1 r1 0 %h", out_valid, out_round, round_err, y, exp_q[0].y);
    end
  endtask

  task automatic test_random();
    bit v, first, ordy;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      v = ($urandom_range(0, 3) != 0);
      first = (m_rcnt == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 3) != 0);
      tick(v, first, rnd64(), rnd64(), ordy);
    end
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1);
    total++; if (act_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_count: got %0d want %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (act_q[i].y !== exp_q[i].y || act_q[i].rnd !== exp_q[i].rnd || act_q[i].last !== exp_q[i].last) begin
        bad++; $display("FAIL rnd_beat%0d: got %h r%0d l%b want %h r%0d l%b", i, act_q[i].y, act_q[i].rnd,
                        act_q[i].last, exp_q[i].y, exp_q[i].rnd, exp_q[i].last);
      end
    end
    total++; if (round_err !== m_err) begin bad++; $display("FAIL rnd_err: got %b want %b", round_err, m_err); end
  endtask

  initial begin
    test_reset();
    test_fwd_sr();
    test_inv_sr();
    test_full_block();
    test_backpressure();
    test_protocol();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
